// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of writeback, multi-cycle and register-file write signals shared by the
// arbiter (slave) and the pipeline / test driver (master).
interface regfile_wb_arbiter_if;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mc_valid;
  logic [4:0]  mc_rd;
  logic [31:0] mc_data;
  logic        mc_ready;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        rs1_hit;
  logic        rs2_hit;
  logic        WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic        stall;
  logic        busy;

  modport master (
    output wb_we, wb_rd, wb_data, mc_valid, mc_rd, mc_data, rs1, rs2,
    input  mc_ready, rs1_hit, rs2_hit, WE3, A3, WD3, stall, busy
  );

  modport slave (
    input  wb_we, wb_rd, wb_data, mc_valid, mc_rd, mc_data, rs1, rs2,
    output mc_ready, rs1_hit, rs2_hit, WE3, A3, WD3, stall, busy
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority over a 2-entry
// multi-cycle FIFO. Optional starvation guard enabled by macro REGFILE_STARVE_GUARD_EN.
module regfile_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_arbiter_if.slave  bus
);

  localparam int DEPTH = 2;

  logic [4:0]  rd_q   [DEPTH];
  logic [31:0] data_q [DEPTH];
  logic [1:0]  count_q, count_d;
  logic        head_q, head_d;
  logic        tail_q, tail_d;

  logic        we3_q, we3_d;
  logic [4:0]  a3_q, a3_d;
  logic [31:0] wd3_q, wd3_d;

  logic        stall;
  logic        mc_ready;
  logic        enq;
  logic        pipe_req;
  logic        head_req;
  logic        grant_pipe;
  logic        grant_head;

  logic [DEPTH-1:0] entry_valid;
  logic [DEPTH-1:0] hit1;
  logic [DEPTH-1:0] hit2;

  assign mc_ready   = (count_q < 2'd2);
  // A handshake with rd=0 completes but never occupies a slot.
  assign enq        = bus.mc_valid && mc_ready && (bus.mc_rd != 5'd0);
  assign pipe_req   = bus.wb_we && (bus.wb_rd != 5'd0) && !stall;
  assign head_req   = (count_q != 2'd0);
  assign grant_pipe = pipe_req;
  assign grant_head = !pipe_req && head_req;

  always_comb begin
    count_d = count_q;
    case ({enq, grant_head})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    head_d = head_q ^ grant_head;
    tail_d = tail_q ^ enq;
  end

  always_comb begin
    we3_d = grant_pipe || grant_head;
    a3_d  = a3_q;
    wd3_d = wd3_q;
    if (grant_pipe) begin
      a3_d  = bus.wb_rd;
      wd3_d = bus.wb_data;
    end else if (grant_head) begin
      a3_d  = rd_q[head_q];
      wd3_d = data_q[head_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      we3_q   <= 1'b0;
      a3_q    <= 5'd0;
      wd3_q   <= 32'd0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      we3_q   <= we3_d;
      a3_q    <= a3_d;
      wd3_q   <= wd3_d;
    end
  end

  // Payload storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (!rst && enq) begin
      rd_q[tail_q]   <= bus.mc_rd;
      data_q[tail_q] <= bus.mc_data;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign entry_valid[gi] = (count_q == 2'd2) ||
                               ((count_q == 2'd1) && (head_q == 1'(gi)));
      assign hit1[gi] = entry_valid[gi] && (rd_q[gi] == bus.rs1);
      assign hit2[gi] = entry_valid[gi] && (rd_q[gi] == bus.rs2);
    end
  endgenerate

`ifdef REGFILE_STARVE_GUARD_EN
  logic [3:0] starve_q, starve_d;
  logic       stall_q, stall_d;

  // Counts pipe wins while the FIFO waits; hitting the limit forces one head issue.
  always_comb begin
    starve_d = starve_q;
    if (!head_req || grant_head) begin
      starve_d = 4'd0;
    end else if (grant_pipe) begin
      starve_d = starve_q + 4'd1;
    end
    stall_d = (starve_d == 4'(STARVE_LIMIT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= 4'd0;
      stall_q  <= 1'b0;
    end else begin
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  assign stall = stall_q;
`else
  assign stall = 1'b0;
`endif

  assign bus.mc_ready = mc_ready;
  assign bus.rs1_hit  = (|hit1) && (bus.rs1 != 5'd0);
  assign bus.rs2_hit  = (|hit2) && (bus.rs2 != 5'd0);
  assign bus.WE3      = we3_q;
  assign bus.A3       = a3_q;
  assign bus.WD3      = wd3_q;
  assign bus.stall    = stall;
  assign bus.busy     = head_req;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter; expectations follow REGFILE_STARVE_GUARD_EN.
module tb_regfile_wb_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

`ifdef REGFILE_STARVE_GUARD_EN
  localparam logic GUARD = 1'b1;
`else
  localparam logic GUARD = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic wb(input logic we, input logic [4:0] rd, input logic [31:0] d);
    bus.wb_we = we; bus.wb_rd = rd; bus.wb_data = d;
  endtask

  task automatic mc(input logic v, input logic [4:0] rd, input logic [31:0] d);
    bus.mc_valid = v; bus.mc_rd = rd; bus.mc_data = d;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    wb(1'b0, 5'd0, 32'd0);
    mc(1'b0, 5'd0, 32'd0);
    bus.rs1 = 5'd0; bus.rs2 = 5'd0;
    tick(); tick();
    check("rst_we3",    {31'd0, bus.WE3},      32'd0);
    check("rst_a3",     {27'd0, bus.A3},       32'd0);
    check("rst_wd3",    bus.WD3,               32'd0);
    check("rst_stall",  {31'd0, bus.stall},    32'd0);
    check("rst_busy",   {31'd0, bus.busy},     32'd0);
    check("rst_ready",  {31'd0, bus.mc_ready}, 32'd1);
    rst = 1'b0;

    // Pipe write, one-cycle latency, then hold when idle
    wb(1'b1, 5'd5, 32'hA5A5A5A5);
    tick();
    check("pipe_we3", {31'd0, bus.WE3}, 32'd1);
    check("pipe_a3",  {27'd0, bus.A3},  32'd5);
    check("pipe_wd3", bus.WD3,          32'hA5A5A5A5);
    wb(1'b1, 5'd0, 32'h12345678);
    tick();
    check("rd0_we3",  {31'd0, bus.WE3}, 32'd0);
    check("hold_a3",  {27'd0, bus.A3},  32'd5);
    check("hold_wd3", bus.WD3,          32'hA5A5A5A5);
    wb(1'b0, 5'd0, 32'd0);

    // Two mc writes to rd=7, in order, no issue in enqueue cycle
    mc(1'b1, 5'd7, 32'h11);
    tick();
    check("enq_no_issue", {31'd0, bus.WE3},  32'd0);
    check("enq_busy",     {31'd0, bus.busy}, 32'd1);
    mc(1'b1, 5'd7, 32'h22);
    tick();
    check("mc1_a3",  {27'd0, bus.A3}, 32'd7);
    check("mc1_wd3", bus.WD3,         32'h11);
    mc(1'b0, 5'd0, 32'd0);
    tick();
    check("mc2_we3",  {31'd0, bus.WE3},  32'd1);
    check("mc2_wd3",  bus.WD3,           32'h22);
    check("mc2_busy", {31'd0, bus.busy}, 32'd0);
    tick();
    check("mc_idle", {31'd0, bus.WE3}, 32'd0);

    // Fill FIFO behind a busy pipe; third request refused while full
    wb(1'b1, 5'd4, 32'h44);
    mc(1'b1, 5'd8, 32'h81);
    tick();
    mc(1'b1, 5'd9, 32'h92);
    tick();
    check("full_ready", {31'd0, bus.mc_ready}, 32'd0);
    bus.rs1 = 5'd8; bus.rs2 = 5'd9;
    mc(1'b1, 5'd10, 32'hA0);
    #1;
    check("full_hit1", {31'd0, bus.rs1_hit}, 32'd1);
    check("full_hit2", {31'd0, bus.rs2_hit}, 32'd1);
    tick();
    check("full_pipe", {27'd0, bus.A3}, 32'd4);
    wb(1'b0, 5'd0, 32'd0);
    tick();
    check("pop8_a3",  {27'd0, bus.A3},       32'd8);
    check("pop8_wd3", bus.WD3,               32'h81);
    check("pop8_rdy", {31'd0, bus.mc_ready}, 32'd1);
    tick();
    check("pop9_wd3", bus.WD3,           32'h92);
    check("pop9_busy", {31'd0, bus.busy}, 32'd1);
    mc(1'b0, 5'd0, 32'd0);
    tick();
    check("pop10_a3",  {27'd0, bus.A3},  32'd10);
    check("pop10_wd3", bus.WD3,          32'hA0);
    tick();
    check("drain_we3", {31'd0, bus.WE3}, 32'd0);

    // Hazard hits; rd=0 handshake completes but is not buffered
    mc(1'b1, 5'd3, 32'h33);
    tick();
    bus.rs1 = 5'd3; bus.rs2 = 5'd0;
    mc(1'b1, 5'd0, 32'hFF);
    #1;
    check("hit_rs1",   {31'd0, bus.rs1_hit},  32'd1);
    check("hit_rs2_0", {31'd0, bus.rs2_hit},  32'd0);
    check("rd0_ready", {31'd0, bus.mc_ready}, 32'd1);
    tick();
    mc(1'b0, 5'd0, 32'd0);
    check("pop3_a3",   {27'd0, bus.A3},      32'd3);
    check("rd0_busy",  {31'd0, bus.busy},    32'd0);
    check("nohit_rs1", {31'd0, bus.rs1_hit}, 32'd0);
    tick();
    check("rd0_nowr", {31'd0, bus.WE3}, 32'd0);
    bus.rs1 = 5'd0;

    // Starvation: one buffered entry against continuous pipe writes
    mc(1'b1, 5'd12, 32'hC0);
    tick();
    mc(1'b0, 5'd0, 32'd0);
    wb(1'b1, 5'd6, 32'h60);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("starve_a3",    {27'd0, bus.A3},    32'd6);
      check("starve_stall", {31'd0, bus.stall}, {31'd0, GUARD && (i == 4)});
    end
`ifdef REGFILE_STARVE_GUARD_EN
    tick();
    check("forced_a3",  {27'd0, bus.A3},    32'd12);
    check("forced_wd3", bus.WD3,            32'hC0);
    check("stall_off",  {31'd0, bus.stall}, 32'd0);
    tick();
    check("held_a3",  {27'd0, bus.A3}, 32'd6);
    check("held_wd3", bus.WD3,         32'h60);
    wb(1'b0, 5'd0, 32'd0);
`else
    wb(1'b0, 5'd0, 32'd0);
    tick();
    check("late_a3",   {27'd0, bus.A3},    32'd12);
    check("late_wd3",  bus.WD3,            32'hC0);
    check("nostall",   {31'd0, bus.stall}, 32'd0);
`endif
    tick();
    check("starve_idle", {31'd0, bus.WE3}, 32'd0);

    // Reset with FIFO full and (guarded build) stall pulse active
    wb(1'b1, 5'd6, 32'h60);
    mc(1'b1, 5'd13, 32'hD0);
    tick();
    mc(1'b1, 5'd14, 32'hE0);
    tick();
    mc(1'b0, 5'd0, 32'd0);
    check("pre_rst_ready", {31'd0, bus.mc_ready}, 32'd0);
    tick(); tick(); tick();
    check("pre_rst_stall", {31'd0, bus.stall}, {31'd0, GUARD});
    rst = 1'b1;
    mc(1'b1, 5'd15, 32'hF0);
    tick();
    rst = 1'b0;
    mc(1'b0, 5'd0, 32'd0);
    wb(1'b0, 5'd0, 32'd0);
    check("mrst_stall", {31'd0, bus.stall},    32'd0);
    check("mrst_we3",   {31'd0, bus.WE3},      32'd0);
    check("mrst_a3",    {27'd0, bus.A3},       32'd0);
    check("mrst_wd3",   bus.WD3,               32'd0);
    check("mrst_busy",  {31'd0, bus.busy},     32'd0);
    check("mrst_ready", {31'd0, bus.mc_ready}, 32'd1);
    tick();
    check("post_rst_we3",  {31'd0, bus.WE3},  32'd0);
    check("post_rst_busy", {31'd0, bus.busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
